// File: rtl/pattern_scan_ctrl_if.sv
// Bundles the configuration, serial input and status signals of pattern_scan_ctrl.
// The controller uses the slave modport. The master modport is for whatever drives it.
interface pattern_scan_ctrl_if #(parameter int CNT_W = 8);
  logic             start;
  logic             abort;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [7:0]       cfg_window;
  logic             in_valid;
  logic             in_bit;
  logic             busy;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             done;

  modport slave (
    input  start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, in_valid, in_bit,
    output busy, match, match_cnt, done
  );

  modport master (
    output start, abort, cfg_pattern, cfg_len, cfg_overlap, cfg_window, in_valid, in_bit,
    input  busy, match, match_cnt, done
  );
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Serial bit-pattern scanner. It counts matches of a 2..8 bit pattern over a window of valid input bits.
// The pattern is either overlapping or non-overlapping. All outputs are registered.
//
// state | meaning
// IDLE  | waiting for start; match_cnt holds the last result
// SCAN  | consuming valid bits until the window is exhausted or aborted
// DONE  | one-cycle done pulse, then back to IDLE
module pattern_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  pattern_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [7:0]       r_pat;
  logic [3:0]       r_len;
  logic             r_ovl;
  logic [7:0]       r_win;
  logic [7:0]       r_shift;
  logic [3:0]       r_fill;
  logic [7:0]       r_bits;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_match;
  logic             r_done;

  logic [7:0]       w_shift_nxt;
  logic [3:0]       w_fill_inc;
  logic [7:0]       w_bits_inc;
  logic [7:0]       w_mask;
  logic [3:0]       w_len_clamp;
  logic             w_hit;

  always_comb begin
    w_shift_nxt = {r_shift[6:0], bus.in_bit};
    w_fill_inc  = (r_fill >= r_len) ? r_len : r_fill + 4'd1;
    w_bits_inc  = r_bits + 8'd1;
    w_mask      = 8'hFF >> (4'd8 - r_len);
    w_hit       = bus.in_valid && (w_fill_inc >= r_len) &&
                  (((w_shift_nxt ^ r_pat) & w_mask) == 8'h00);
    w_len_clamp = (bus.cfg_len < 4'd2) ? 4'd2 :
                  (bus.cfg_len > 4'd8) ? 4'd8 : bus.cfg_len;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = (bus.cfg_window == 8'd0) ? DONE : SCAN;
      // abort wins over a window-completing bit
      SCAN: begin
        if (bus.abort)                                w_state_nxt = IDLE;
        else if (bus.in_valid && w_bits_inc == r_win) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat   <= '0;
      r_len   <= 4'd2;
      r_ovl   <= 1'b0;
      r_win   <= '0;
      r_shift <= '0;
      r_fill  <= '0;
      r_bits  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_match <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == DONE);
      r_match <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_pat   <= bus.cfg_pattern;
          r_len   <= w_len_clamp;
          r_ovl   <= bus.cfg_overlap;
          r_win   <= bus.cfg_window;
          r_shift <= '0;
          r_fill  <= '0;
          r_bits  <= '0;
          r_cnt   <= '0;
        end
        // a match in an abort cycle still counts, so the datapath ignores abort
        SCAN: if (bus.in_valid) begin
          r_shift <= w_shift_nxt;
          r_bits  <= w_bits_inc;
          if (w_hit) begin
            r_match <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
            r_fill  <= r_ovl ? w_fill_inc : 4'd0;
          end else begin
            r_fill  <= w_fill_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.match     = r_match;
  assign bus.match_cnt = r_cnt;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl. Expected values are hand-derived from the bit streams below.
module tb_pattern_scan_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  pattern_scan_ctrl_if #(.CNT_W(8)) bus ();

  pattern_scan_ctrl #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                     input logic [7:0] win);
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ovl;
    bus.cfg_window  = win;
  endtask

  // bits[n-1] is sent first; expm[i] is the match expected after sending bits[i]
  task automatic run_bits(input string tag, input logic [15:0] bits, input int n,
                          input logic [15:0] expm, input logic last_done);
    for (int i = n - 1; i >= 0; i--) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[i];
      tick();
      chk({tag, " match"}, 32'(bus.match), 32'(expm[i]));
      chk({tag, " done"},  32'(bus.done),  32'((i == 0) && last_done));
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;
    cfg(8'h00, 4'd2, 1'b0, 8'd0);
    tick(); tick();
    chk("rst busy", 32'(bus.busy), 0);
    chk("rst match", 32'(bus.match), 0);
    chk("rst done", 32'(bus.done), 0);
    chk("rst cnt", 32'(bus.match_cnt), 0);

    // Overlapping 1011 search. start is accepted on the first edge with rst low.
    cfg(8'h0B, 4'd4, 1'b1, 8'd8);
    rst = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("ovl busy", 32'(bus.busy), 1);
    chk("ovl cnt0", 32'(bus.match_cnt), 0);
    run_bits("ovl", 16'b1011_0110, 8, 16'b0001_0010, 1'b1);
    chk("ovl cnt", 32'(bus.match_cnt), 2);
    chk("ovl busy done", 32'(bus.busy), 1);
    tick();
    chk("ovl done off", 32'(bus.done), 0);
    chk("ovl idle busy", 32'(bus.busy), 0);
    chk("ovl cnt hold", 32'(bus.match_cnt), 2);

    // Non-overlapping 1011 search on the same stream.
    cfg(8'h0B, 4'd4, 1'b0, 8'd8);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("novl cnt clr", 32'(bus.match_cnt), 0);
    run_bits("novl", 16'b1011_0110, 8, 16'b0001_0000, 1'b1);
    chk("novl cnt", 32'(bus.match_cnt), 1);
    tick();

    // An empty window goes straight to DONE.
    cfg(8'h03, 4'd2, 1'b1, 8'd0);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("win0 done", 32'(bus.done), 1);
    chk("win0 busy", 32'(bus.busy), 1);
    chk("win0 cnt", 32'(bus.match_cnt), 0);
    tick();
    chk("win0 done off", 32'(bus.done), 0);
    chk("win0 busy off", 32'(bus.busy), 0);

    // Pattern 11 over all ones, with idle gaps between the valid bits.
    cfg(8'h03, 4'd2, 1'b1, 8'd6);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      bus.in_valid = 1'b1; bus.in_bit = 1'b1;
      tick();
      bus.in_valid = 1'b0; bus.in_bit = 1'b0;
      chk("gap match", 32'(bus.match), 32'(k > 1));
      chk("gap cnt", 32'(bus.match_cnt), 32'(k - 1));
      chk("gap done", 32'(bus.done), 32'(k == 6));
      if (k < 6) begin
        tick();
        chk("gap idle match", 32'(bus.match), 0);
        chk("gap idle cnt", 32'(bus.match_cnt), 32'(k - 1));
      end
    end
    tick();
    chk("gap final cnt", 32'(bus.match_cnt), 5);

    // A length of 1 is used as 2, and cfg changes during the scan are ignored.
    cfg(8'h03, 4'd1, 1'b1, 8'd4);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    cfg(8'h00, 4'd8, 1'b0, 8'd2);
    run_bits("len1", 16'b1011, 4, 16'b0001, 1'b1);
    chk("len1 cnt", 32'(bus.match_cnt), 1);
    tick();

    // A length of 12 is used as 8. start is held high mid-scan and is ignored.
    cfg(8'hA5, 4'd12, 1'b0, 8'd10);
    bus.start = 1'b1; tick();
    run_bits("len12", 16'b10_1001_0110, 10, 16'b00_0000_0100, 1'b1);
    bus.start = 1'b0;
    chk("len12 cnt", 32'(bus.match_cnt), 1);
    tick();
    chk("len12 idle", 32'(bus.busy), 0);

    // Abort after 3 bits keeps the partial count and gives no done.
    cfg(8'h03, 4'd2, 1'b1, 8'd8);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_bits("abt", 16'b111, 3, 16'b011, 1'b0);
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
    chk("abt busy", 32'(bus.busy), 0);
    chk("abt done", 32'(bus.done), 0);
    chk("abt cnt", 32'(bus.match_cnt), 2);
    tick();
    chk("abt done2", 32'(bus.done), 0);
    chk("abt cnt2", 32'(bus.match_cnt), 2);

    // Abort on the window-completing bit: the match is still counted, but no done.
    cfg(8'h03, 4'd2, 1'b1, 8'd2);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_bits("abw", 16'b1, 1, 16'b0, 1'b0);
    bus.abort = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    tick();
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    chk("abw match", 32'(bus.match), 1);
    chk("abw done", 32'(bus.done), 0);
    chk("abw cnt", 32'(bus.match_cnt), 1);
    chk("abw busy", 32'(bus.busy), 0);
    tick();
    chk("abw done2", 32'(bus.done), 0);

    // Reset during a scan clears everything. Reset also wins over start.
    cfg(8'h03, 4'd2, 1'b1, 8'd8);
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    run_bits("rsc", 16'b11, 2, 16'b01, 1'b0);
    chk("rsc cnt", 32'(bus.match_cnt), 1);
    rst = 1'b1; bus.start = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b1;
    tick();
    chk("rsc busy", 32'(bus.busy), 0);
    chk("rsc match", 32'(bus.match), 0);
    chk("rsc done", 32'(bus.done), 0);
    chk("rsc cnt0", 32'(bus.match_cnt), 0);
    bus.in_valid = 1'b0;
    tick();
    chk("rst vs start", 32'(bus.busy), 0);
    rst = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("post rst start", 32'(bus.busy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
